// File: rtl/load_unit_split.sv
// Load unit between LSU issue and the data-memory port: one or two aligned bus
// reads per load, little-endian byte assembly, sign/zero extension to XLEN.
`timescale 1ns/1ps
module load_unit_split #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned ADDR_W   = 32,
  parameter bit          SPLIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_wdt,
  input  logic              req_unsigned,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [XLEN-1:0]   res_data,
  output logic              res_err
);

  localparam int unsigned B     = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(B);
  localparam int unsigned WA_W  = ADDR_W - OFF_W;
  localparam int unsigned DW    = 2 * XLEN;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ0 = 3'd1,
    RSP0 = 3'd2,
    REQ1 = 3'd3,
    RSP1 = 3'd4,
    RESP = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [WA_W-1:0]   word_q, word_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [3:0]        wdt_q, wdt_d;
  logic              uns_q, uns_d;
  logic              cross_q, cross_d;
  logic [XLEN-1:0]   beat0_q, beat0_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
  logic              res_valid_q, res_valid_d;
  logic [XLEN-1:0]   res_data_q, res_data_d;
  logic              res_err_q, res_err_d;

  logic [OFF_W-1:0]  req_off;
  logic [4:0]        req_n;
  logic [4:0]        req_end;
  logic              req_cross;
  logic              req_onehot;
  logic              req_illegal;

  // Shift the two beats down by the byte offset, then extend the selected width.
  function automatic logic [XLEN-1:0] assemble(
    input logic [XLEN-1:0]  hi,
    input logic [XLEN-1:0]  lo,
    input logic [OFF_W-1:0] off,
    input logic [3:0]       wdt,
    input logic             uns
  );
    logic [DW-1:0]   cat;
    logic [XLEN-1:0] r;
    cat = {hi, lo} >> {off, 3'b000};
    r   = cat[XLEN-1:0];
    case (wdt)
      4'b0001: begin
        if (uns) assemble = XLEN'(r[7:0]);
        else     assemble = XLEN'($signed(r[7:0]));
      end
      4'b0010: begin
        if (uns) assemble = XLEN'(r[15:0]);
        else     assemble = XLEN'($signed(r[15:0]));
      end
      4'b0100: begin
        if (uns) assemble = XLEN'(r[31:0]);
        else     assemble = XLEN'($signed(r[31:0]));
      end
      default: assemble = r;
    endcase
  endfunction

  // Request decode: byte count, boundary crossing and legality.
  always_comb begin
    req_off = req_addr[OFF_W-1:0];
    case (req_wdt)
      4'b0001: req_n = 5'd1;
      4'b0010: req_n = 5'd2;
      4'b0100: req_n = 5'd4;
      4'b1000: req_n = 5'd8;
      default: req_n = 5'd0;
    endcase
    req_end     = 5'(req_off) + req_n;
    req_cross   = (req_end > 5'(B));
    req_onehot  = (req_wdt != 4'd0) && ((req_wdt & (req_wdt - 4'd1)) == 4'd0);
    req_illegal = !req_onehot || ((XLEN == 32) && req_wdt[3]) || (req_cross && !SPLIT_EN);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    word_d         = word_q;
    off_d          = off_q;
    wdt_d          = wdt_q;
    uns_d          = uns_q;
    cross_d        = cross_q;
    beat0_d        = beat0_q;
    mem_req_addr_d = mem_req_addr_q;
    res_data_d     = res_data_q;
    res_err_d      = res_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          word_d  = req_addr[ADDR_W-1:OFF_W];
          off_d   = req_off;
          wdt_d   = req_wdt;
          uns_d   = req_unsigned;
          cross_d = req_cross;
          if (req_illegal) begin
            state_d    = RESP;
            res_err_d  = 1'b1;
            res_data_d = '0;
          end else begin
            state_d        = REQ0;
            res_err_d      = 1'b0;
            mem_req_addr_d = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          end
        end
      end
      REQ0: begin
        if (mem_req_ready) state_d = RSP0;
      end
      RSP0: begin
        if (mem_rsp_valid) begin
          beat0_d = mem_rdata;
          if (cross_q) begin
            state_d        = REQ1;
            mem_req_addr_d = {word_q + WA_W'(1), {OFF_W{1'b0}}};
          end else begin
            state_d    = RESP;
            res_data_d = assemble('0, mem_rdata, off_q, wdt_q, uns_q);
          end
        end
      end
      REQ1: begin
        if (mem_req_ready) state_d = RSP1;
      end
      RSP1: begin
        if (mem_rsp_valid) begin
          state_d    = RESP;
          res_data_d = assemble(mem_rdata, beat0_q, off_q, wdt_q, uns_q);
        end
      end
      RESP: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d     = (state_d == IDLE);
    mem_req_valid_d = (state_d == REQ0) || (state_d == REQ1);
    res_valid_d     = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      word_q          <= '0;
      off_q           <= '0;
      wdt_q           <= '0;
      uns_q           <= 1'b0;
      cross_q         <= 1'b0;
      beat0_q         <= '0;
      req_ready_q     <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      res_valid_q     <= 1'b0;
      res_data_q      <= '0;
      res_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      word_q          <= word_d;
      off_q           <= off_d;
      wdt_q           <= wdt_d;
      uns_q           <= uns_d;
      cross_q         <= cross_d;
      beat0_q         <= beat0_d;
      req_ready_q     <= req_ready_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      res_valid_q     <= res_valid_d;
      res_data_q      <= res_data_d;
      res_err_q       <= res_err_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign res_err       = res_err_q;

endmodule

// File: tb/tb_load_unit_split.sv
// Directed bench for load_unit_split: vector table plus hand-written
// backpressure, split-disabled and reset-mid-load sequences.
`timescale 1ns/1ps
module tb_load_unit_split;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_valid_b = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_wdt = 4'b0001;
  logic        req_unsigned = 1'b0;
  logic        mem_req_ready = 1'b1;
  logic        res_ready = 1'b1;

  logic        req_ready, mem_req_valid, res_valid, res_err;
  logic [31:0] mem_req_addr;
  logic [63:0] res_data;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;

  logic        req_ready_b, mem_req_valid_b, res_valid_b, res_err_b;
  logic [31:0] mem_req_addr_b;
  logic [63:0] res_data_b;
  logic        rsp_valid_b = 1'b0;
  logic [63:0] rdata_b = '0;

  // Memory model state
  logic        pend = 1'b0;
  int          cnt = 0;
  int          rsp_delay = 0;
  logic [31:0] rsp_addr = '0;
  logic        stray = 1'b0;
  logic [31:0] req_log [256];
  int          req_n = 0;
  int          b_req_n = 0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  load_unit_split #(.XLEN(64), .ADDR_W(32), .SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdt(req_wdt), .req_unsigned(req_unsigned),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
  );

  load_unit_split #(.XLEN(64), .ADDR_W(32), .SPLIT_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr),
    .req_wdt(req_wdt), .req_unsigned(req_unsigned),
    .mem_req_valid(mem_req_valid_b), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr_b),
    .mem_rsp_valid(rsp_valid_b), .mem_rdata(rdata_b),
    .res_valid(res_valid_b), .res_ready(res_ready), .res_data(res_data_b), .res_err(res_err_b)
  );

  function automatic logic [63:0] mem_read(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 64'h0123_4567_89AB_CDEF;
      32'h8000_0008: return 64'hFEDC_BA98_7654_3210;
      32'h8000_0010: return 64'h1111_1111_1111_1177;
      32'hFFFF_FFF8: return 64'hAABB_CCDD_0000_0000;
      32'h0000_0000: return 64'h0000_0000_0000_5566;
      default:       return 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
  endfunction

  assign mem_rsp_valid = (pend && cnt == 0) || stray;
  assign mem_rdata     = mem_read(rsp_addr);

  // Bus slave: one outstanding read, answered rsp_delay cycles after the handshake
  always @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      cnt  <= 0;
    end else begin
      if (pend && cnt == 0) pend <= 1'b0;
      else if (pend) cnt <= cnt - 1;
      if (mem_req_valid && mem_req_ready) begin
        pend <= 1'b1;
        cnt  <= rsp_delay;
        rsp_addr <= mem_req_addr;
        req_log[req_n % 256] <= mem_req_addr;
        req_n <= req_n + 1;
      end
      if (mem_req_valid_b) b_req_n <= b_req_n + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_res(output int lat);
    lat = 1;
    while (!res_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!res_valid) chk("res_valid_timeout", 64'(res_valid), 64'd1);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [3:0] w, input logic u,
                         output logic [63:0] d, output logic e, output int lat,
                         output int base, output int nreq);
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_addr = a; req_wdt = w; req_unsigned = u; req_valid = 1'b1;
    base = req_n;
    @(negedge clk);
    req_valid = 1'b0;
    wait_res(lat);
    d = res_data;
    e = res_err;
    nreq = req_n - base;
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wdt;
    logic        uns;
    logic [63:0] data;
    logic        err;
    int          nreq;
    logic [31:0] a0;
    logic [31:0] a1;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    logic        e;
    int lat, base, nreq, lat_nc, lat_cr;

    vecs[0]  = '{32'h8000_0001, 4'b0001, 1'b0, 64'hFFFF_FFFF_FFFF_FFCD, 1'b0, 1, 32'h8000_0000, 32'h0};
    vecs[1]  = '{32'h8000_0001, 4'b0001, 1'b1, 64'h0000_0000_0000_00CD, 1'b0, 1, 32'h8000_0000, 32'h0};
    vecs[2]  = '{32'h8000_0006, 4'b0100, 1'b0, 64'h0000_0000_3210_0123, 1'b0, 2, 32'h8000_0000, 32'h8000_0008};
    vecs[3]  = '{32'h8000_0000, 4'b1000, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, 1, 32'h8000_0000, 32'h0};
    vecs[4]  = '{32'h8000_0000, 4'b1000, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 1, 32'h8000_0000, 32'h0};
    vecs[5]  = '{32'h8000_0002, 4'b0010, 1'b0, 64'hFFFF_FFFF_FFFF_89AB, 1'b0, 1, 32'h8000_0000, 32'h0};
    vecs[6]  = '{32'h8000_0002, 4'b0010, 1'b1, 64'h0000_0000_0000_89AB, 1'b0, 1, 32'h8000_0000, 32'h0};
    vecs[7]  = '{32'h8000_0004, 4'b0100, 1'b0, 64'h0000_0000_0123_4567, 1'b0, 1, 32'h8000_0000, 32'h0};
    vecs[8]  = '{32'h8000_000C, 4'b0100, 1'b0, 64'hFFFF_FFFF_FEDC_BA98, 1'b0, 1, 32'h8000_0008, 32'h0};
    vecs[9]  = '{32'h8000_000C, 4'b0100, 1'b1, 64'h0000_0000_FEDC_BA98, 1'b0, 1, 32'h8000_0008, 32'h0};
    vecs[10] = '{32'h8000_0007, 4'b0010, 1'b0, 64'h0000_0000_0000_1001, 1'b0, 2, 32'h8000_0000, 32'h8000_0008};
    vecs[11] = '{32'h8000_0009, 4'b1000, 1'b0, 64'h77FE_DCBA_9876_5432, 1'b0, 2, 32'h8000_0008, 32'h8000_0010};
    vecs[12] = '{32'hFFFF_FFFE, 4'b0100, 1'b0, 64'h0000_0000_5566_AABB, 1'b0, 2, 32'hFFFF_FFF8, 32'h0000_0000};
    vecs[13] = '{32'h8000_0000, 4'b0110, 1'b0, 64'h0,                   1'b1, 0, 32'h0,         32'h0};
    vecs[14] = '{32'h8000_0003, 4'b0000, 1'b1, 64'h0,                   1'b1, 0, 32'h0,         32'h0};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_mem_req_addr", 64'(mem_req_addr), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    chk("rst_res_err", 64'(res_err), 64'd0);
    rst = 1'b0;

    lat_nc = 0;
    lat_cr = 0;
    for (int i = 0; i < NV; i++) begin
      do_load(vecs[i].addr, vecs[i].wdt, vecs[i].uns, d, e, lat, base, nreq);
      chk($sformatf("v%0d_data", i), d, vecs[i].data);
      chk($sformatf("v%0d_err", i), 64'(e), 64'(vecs[i].err));
      chk($sformatf("v%0d_nreq", i), 64'(nreq), 64'(vecs[i].nreq));
      if (vecs[i].nreq >= 1) chk($sformatf("v%0d_a0", i), 64'(req_log[base % 256]), 64'(vecs[i].a0));
      if (vecs[i].nreq >= 2) chk($sformatf("v%0d_a1", i), 64'(req_log[(base + 1) % 256]), 64'(vecs[i].a1));
      if (vecs[i].err) chk($sformatf("v%0d_err_latency", i), 64'(lat), 64'd1);
      if (i == 0) lat_nc = lat;
      if (i == 2) lat_cr = lat;
    end
    chk("cross_extra_latency", 64'(lat_cr), 64'(lat_nc + 2));

    // Crossing load with splitting disabled
    @(negedge clk);
    req_addr = 32'h8000_0006; req_wdt = 4'b0100; req_unsigned = 1'b0; req_valid_b = 1'b1;
    @(negedge clk);
    req_valid_b = 1'b0;
    chk("nosplit_res_valid", 64'(res_valid_b), 64'd1);
    chk("nosplit_res_err", 64'(res_err_b), 64'd1);
    chk("nosplit_res_data", res_data_b, 64'd0);
    @(negedge clk);
    chk("nosplit_back_idle", 64'(req_ready_b), 64'd1);
    chk("nosplit_no_bus", 64'(b_req_n), 64'd0);

    // Bus request backpressure
    mem_req_ready = 1'b0;
    req_addr = 32'h8000_0001; req_wdt = 4'b0001; req_unsigned = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_mem_valid_%0d", k), 64'(mem_req_valid), 64'd1);
      chk($sformatf("bp_mem_addr_%0d", k), 64'(mem_req_addr), 64'h8000_0000);
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    wait_res(lat);
    chk("bp_mem_data", res_data, 64'hFFFF_FFFF_FFFF_FFCD);
    @(negedge clk);

    // Result backpressure
    res_ready = 1'b0;
    req_addr = 32'h8000_0002; req_wdt = 4'b0010; req_unsigned = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    wait_res(lat);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_res_valid_%0d", k), 64'(res_valid), 64'd1);
      chk($sformatf("bp_res_data_%0d", k), res_data, 64'h89AB);
      chk($sformatf("bp_res_req_ready_%0d", k), 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_res_released", 64'(res_valid), 64'd0);
    chk("bp_res_idle", 64'(req_ready), 64'd1);

    // Reset while waiting in RSP0, then a stray response in IDLE
    rsp_delay = 10;
    req_addr = 32'h8000_0000; req_wdt = 4'b1000; req_unsigned = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_in_rsp0_req", 64'(mem_req_valid), 64'd0);
    chk("mid_in_rsp0_busy", 64'(req_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_mem_valid", 64'(mem_req_valid), 64'd0);
    chk("mid_rst_mem_addr", 64'(mem_req_addr), 64'd0);
    chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_res_data", res_data, 64'd0);
    chk("mid_rst_res_err", 64'(res_err), 64'd0);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stray_res_valid_%0d", k), 64'(res_valid), 64'd0);
      chk($sformatf("stray_req_ready_%0d", k), 64'(req_ready), 64'd1);
      chk($sformatf("stray_res_data_%0d", k), res_data, 64'd0);
      @(negedge clk);
    end
    rsp_delay = 0;
    do_load(32'h8000_0000, 4'b1000, 1'b0, d, e, lat, base, nreq);
    chk("post_rst_data", d, 64'h0123_4567_89AB_CDEF);
    chk("post_rst_err", 64'(e), 64'd0);
    chk("post_rst_nreq", 64'(nreq), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
